// File: rtl/h_noc_if.sv
// PE-side bundle of the NoC: per-PE ingress and egress valid/ready channels.
// The master modport is the PE array; the slave modport is the NoC.
interface h_noc_if #(
    parameter int N      = 8,
    parameter int DATA_W = 32
);
    logic [N-1:0][DATA_W-1:0] i_pe_data;
    logic [N-1:0]             i_pe_data_valid;
    logic [N-1:0]             o_pe_data_ready;
    logic [N-1:0][DATA_W-1:0] o_pe_data;
    logic [N-1:0]             o_pe_data_valid;
    logic [N-1:0]             i_pe_data_ready;

    modport master (
        output i_pe_data, i_pe_data_valid, i_pe_data_ready,
        input  o_pe_data_ready, o_pe_data, o_pe_data_valid
    );

    modport slave (
        input  i_pe_data, i_pe_data_valid, i_pe_data_ready,
        output o_pe_data_ready, o_pe_data, o_pe_data_valid
    );
endinterface

// File: rtl/h_noc.sv
// Two 5-port switches (4 PEs + uplink) joined by a bridge; input FIFOs, round-robin
// arbiters and registered outputs. Valid shows in cycle 2 intra-cluster, cycle 4 inter.
module h_noc #(
    parameter int DATA_W = 32,
    parameter int FIFO_D = 2
) (
    input  logic   i_clk,
    input  logic   i_reset,
    h_noc_if.slave pe
);
    localparam int AW = (FIFO_D > 1) ? $clog2(FIFO_D) : 1;
    localparam int NP = 5;
    localparam int NK = 2 * NP;

    typedef logic [DATA_W-1:0] flit_t;

    // Index k = cluster*NP + port; port NP-1 is the bridge input / uplink output.
    flit_t         mem_q [NK][FIFO_D];
    flit_t         mem_d [NK][FIFO_D];
    logic [AW-1:0] rp_q [NK];
    logic [AW-1:0] rp_d [NK];
    logic [AW-1:0] wp_q [NK];
    logic [AW-1:0] wp_d [NK];
    logic [AW:0]   cnt_q [NK];
    logic [AW:0]   cnt_d [NK];
    logic [NK-1:0] rdy_q, rdy_d;
    logic [NK-1:0] ov_q, ov_d;
    flit_t         od_q [NK];
    flit_t         od_d [NK];
    logic [2:0]    ptr_q [NK];
    logic [2:0]    ptr_d [NK];

    logic [NK-1:0] push, pop, sink_rdy, out_free, busy;
    flit_t         in_dat [NK];
    flit_t         head [NK];
    logic [2:0]    dport [NK];

    function automatic logic [2:0] route(input int c, input int p, input logic [2:0] dst);
        if (p == NP - 1 || dst[2] == c[0]) begin
            return {1'b0, dst[1:0]};
        end
        return 3'd4;
    endfunction

    always_comb begin
        for (int c = 0; c < 2; c++) begin
            for (int p = 0; p < NP; p++) begin
                if (p < NP - 1) begin
                    in_dat[c*NP+p]   = pe.i_pe_data[c*4+p];
                    push[c*NP+p]     = pe.i_pe_data_valid[c*4+p] && rdy_q[c*NP+p];
                    sink_rdy[c*NP+p] = pe.i_pe_data_ready[c*4+p];
                end else begin
                    in_dat[c*NP+p]   = od_q[(1-c)*NP+p];
                    push[c*NP+p]     = ov_q[(1-c)*NP+p] && rdy_q[c*NP+p];
                    sink_rdy[c*NP+p] = rdy_q[(1-c)*NP+p];
                end
                busy[c*NP+p]     = (cnt_q[c*NP+p] != '0);
                head[c*NP+p]     = mem_q[c*NP+p][rp_q[c*NP+p]];
                dport[c*NP+p]    = route(c, p, head[c*NP+p][DATA_W-1:DATA_W-3]);
                out_free[c*NP+p] = !ov_q[c*NP+p] || sink_rdy[c*NP+p];
            end
        end
    end

    always_comb begin
        mem_d = mem_q;
        rp_d  = rp_q;
        wp_d  = wp_q;
        cnt_d = cnt_q;
        rdy_d = rdy_q;
        ov_d  = ov_q;
        od_d  = od_q;
        ptr_d = ptr_q;
        pop   = '0;
        for (int c = 0; c < 2; c++) begin
            for (int o = 0; o < NP; o++) begin
                int ko;
                int gi;
                int ii;
                ko = c * NP + o;
                gi = -1;
                ii = 0;
                for (int j = 0; j < NP; j++) begin
                    ii = int'(ptr_q[ko]) + j;
                    if (ii >= NP) ii = ii - NP;
                    if (gi < 0 && busy[c*NP+ii] && dport[c*NP+ii] == 3'(o) && out_free[ko]) begin
                        gi = ii;
                    end
                end
                if (gi >= 0) begin
                    pop[c*NP+gi] = 1'b1;
                    ov_d[ko]     = 1'b1;
                    od_d[ko]     = head[c*NP+gi];
                    ptr_d[ko]    = (gi == NP - 1) ? 3'd0 : 3'(gi + 1);
                end else if (sink_rdy[ko]) begin
                    ov_d[ko] = 1'b0;
                end
            end
        end
        // Ready is registered from next occupancy, so a full FIFO is never pushed.
        for (int k = 0; k < NK; k++) begin
            if (push[k]) begin
                mem_d[k][wp_q[k]] = in_dat[k];
                wp_d[k]           = wp_q[k] + AW'(1);
            end
            if (pop[k]) begin
                rp_d[k] = rp_q[k] + AW'(1);
            end
            cnt_d[k] = cnt_q[k] + (AW+1)'(push[k]) - (AW+1)'(pop[k]);
            rdy_d[k] = (cnt_d[k] != (AW+1)'(FIFO_D));
        end
    end

    always_comb begin
        for (int n = 0; n < 8; n++) begin
            pe.o_pe_data_ready[n] = rdy_q[(n/4)*NP + (n%4)];
            pe.o_pe_data_valid[n] = ov_q[(n/4)*NP + (n%4)];
            pe.o_pe_data[n]       = od_q[(n/4)*NP + (n%4)];
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            for (int k = 0; k < NK; k++) begin
                for (int e = 0; e < FIFO_D; e++) begin
                    mem_q[k][e] <= '0;
                end
                rp_q[k]  <= '0;
                wp_q[k]  <= '0;
                cnt_q[k] <= '0;
                od_q[k]  <= '0;
                ptr_q[k] <= '0;
            end
            rdy_q <= '0;
            ov_q  <= '0;
        end else begin
            mem_q <= mem_d;
            rp_q  <= rp_d;
            wp_q  <= wp_d;
            cnt_q <= cnt_d;
            od_q  <= od_d;
            ptr_q <= ptr_d;
            rdy_q <= rdy_d;
            ov_q  <= ov_d;
        end
    end
endmodule

// File: tb/tb_h_noc.sv
// Scoreboard bench for h_noc: per (src,dst) expected queues filled on acceptance,
// drained by a delivery monitor; directed tests for reset, latency, RR, backpressure.
module tb_h_noc;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    h_noc_if #(.N(8), .DATA_W(32)) ifc ();

    h_noc #(.DATA_W(32), .FIFO_D(2)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .pe      (ifc)
    );

    typedef struct {logic [31:0] d; int lat;} tx_t;
    typedef struct {logic [31:0] d; int acc; int lat;} exp_t;

    tx_t  pend [8][$];
    exp_t sb [64][$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   total = 0;
    int   dcnt [8];
    int   vcyc [8];
    bit   rec_rr = 1'b0;
    int   rr_src [$];
    int   rr_cyc [$];

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic send(input int n, input logic [31:0] d, input int lat);
        tx_t t;
        t.d   = d;
        t.lat = lat;
        pend[n].push_back(t);
    endtask

    function automatic int outstanding();
        int s = 0;
        for (int n = 0; n < 8; n++) s += pend[n].size();
        for (int k = 0; k < 64; k++) s += sb[k].size();
        return s;
    endfunction

    task automatic wait_idle(input string nm, input int budget);
        int b = 0;
        while (outstanding() != 0 && b < budget) begin
            @(negedge clk);
            b++;
        end
        repeat (3) @(negedge clk);
        chk(nm, outstanding(), 0);
    endtask

    // Driver: handshakes sampled mid-cycle, acted on just after the edge.
    initial begin
        bit fire [8];
        ifc.i_pe_data       = '0;
        ifc.i_pe_data_valid = '0;
        forever begin
            @(negedge clk);
            for (int n = 0; n < 8; n++) fire[n] = ifc.i_pe_data_valid[n] && ifc.o_pe_data_ready[n];
            @(posedge clk);
            #1;
            for (int n = 0; n < 8; n++) begin
                if (fire[n]) begin
                    tx_t  t;
                    exp_t e;
                    t     = pend[n].pop_front();
                    e.d   = t.d;
                    e.acc = cyc;
                    e.lat = t.lat;
                    sb[int'(t.d[28:26]) * 8 + int'(t.d[31:29])].push_back(e);
                end
                if (pend[n].size() > 0) begin
                    ifc.i_pe_data[n]       = pend[n][0].d;
                    ifc.i_pe_data_valid[n] = 1'b1;
                end else begin
                    ifc.i_pe_data_valid[n] = 1'b0;
                end
            end
        end
    end

    // Monitor: the accept edge opens cycle 1, so latency = edges elapsed + 1.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 8; n++) begin
                if (ifc.o_pe_data_valid[n]) vcyc[n]++;
                if (ifc.o_pe_data_valid[n] && ifc.i_pe_data_ready[n]) begin
                    logic [31:0] d;
                    int          k;
                    exp_t        e;
                    d = ifc.o_pe_data[n];
                    k = int'(d[28:26]) * 8 + n;
                    total++;
                    dcnt[n]++;
                    if (rec_rr && n == 3) begin
                        rr_src.push_back(int'(d[28:26]));
                        rr_cyc.push_back(cyc);
                    end
                    if (sb[k].size() == 0) begin
                        n_chk++;
                        n_fail++;
                        $display("FAIL unexpected delivery at PE%0d: got %08h expected none", n, d);
                    end else begin
                        e = sb[k].pop_front();
                        chk("data", d, e.d);
                        if (e.lat > 0) chk("latency", cyc - e.acc + 1, e.lat);
                    end
                end
            end
        end
    end

    initial begin
        int v0;
        int d0;
        int t0;
        logic [2:0] dst;
        ifc.i_pe_data_ready = 8'hFF;
        for (int n = 0; n < 8; n++) begin
            dcnt[n] = 0;
            vcyc[n] = 0;
        end

        #100;
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", ifc.o_pe_data_valid, 8'h00);
        chk("rst_ready", ifc.o_pe_data_ready, 8'h00);
        chk("rst_data_nonzero", (ifc.o_pe_data != '0), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("ready_after_rst", ifc.o_pe_data_ready, 8'hFF);

        v0 = vcyc[1];
        send(0, 32'h2000_0ABC, 2);
        wait_idle("single_drain", 50);
        chk("single_pulse", vcyc[1] - v0, 1);
        chk("single_cnt", dcnt[1], 1);

        send(2, {3'd6, 3'd2, 26'h55}, 4);
        wait_idle("cross_drain", 50);
        send(7, {3'd0, 3'd7, 26'h3AB_CDEF}, 4);
        wait_idle("cross_back_drain", 50);
        send(5, {3'd5, 3'd5, 26'h123}, 2);
        wait_idle("self_drain", 50);
        chk("self_cnt", dcnt[5], 1);

        rec_rr = 1'b1;
        for (int f = 0; f < 4; f++) begin
            for (int s = 0; s < 3; s++) send(s, {3'd3, 3'(s), 26'(f)}, 0);
        end
        wait_idle("rr_drain", 200);
        rec_rr = 1'b0;
        chk("rr_count", rr_src.size(), 12);
        if (rr_src.size() == 12) begin
            for (int i = 0; i < 12; i++) chk("rr_order", rr_src[i], i % 3);
            chk("rr_span", rr_cyc[11] - rr_cyc[0], 11);
        end

        @(posedge clk);
        #1 ifc.i_pe_data_ready[5] = 1'b0;
        d0 = dcnt[5];
        for (int f = 0; f < 8; f++) send(4, {3'd5, 3'd4, 26'(f + 100)}, 0);
        repeat (20) @(negedge clk);
        chk("bp_ready_low", ifc.o_pe_data_ready[4], 0);
        chk("bp_accepted", 8 - pend[4].size(), 3);
        chk("bp_no_delivery", dcnt[5] - d0, 0);
        @(posedge clk);
        #1 ifc.i_pe_data_ready[5] = 1'b1;
        wait_idle("bp_drain", 200);
        chk("bp_delivered", dcnt[5] - d0, 8);

        t0 = total;
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < 100; i++) begin
                dst = 3'($urandom_range(0, 7));
                send(n, {dst, 3'(n), 26'($urandom)}, 0);
            end
        end
        wait_idle("a2a_drain", 10000);
        chk("a2a_total", total - t0, 800);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
